// File: rtl/audio_pkg.sv
// audio_pkg: shared definitions for the audio DAC transmit path.
//   SAMPLE_W / DAC_WORD_W : sample width and serial word width
//   PD_*                  : DAC121S101 power-down codes carried in word bits [13:12]
//   dac_state_t           : transmitter FSM state encoding
package audio_pkg;

  localparam int SAMPLE_W   = 12;
  localparam int DAC_WORD_W = 16;

  localparam logic [1:0] PD_NORMAL = 2'b00;
  localparam logic [1:0] PD_1K     = 2'b01;
  localparam logic [1:0] PD_100K   = 2'b10;
  localparam logic [1:0] PD_HIZ    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } dac_state_t;

endpackage

// File: rtl/audio_dac_tx_sclk_tick_gen.sv
// sclk_tick_gen: half-period tick generator for the DAC serial clock.
// Counts CLK_DIV clk cycles while enabled; tick is high on the last cycle
// of each half-period so the owner toggles sclk on that edge.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   en         : count enable (transmitter is shifting)
//   clr        : restart the half-period (frame start)
//   tick       : half-period elapsed this cycle
module sclk_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q;

  assign tick = en && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt_q <= 8'd0;
    end else if (en) begin
      cnt_q <= tick ? 8'd0 : cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/audio_dac_tx.sv
// audio_dac_tx: serial transmitter for a DAC121S101-style 12-bit DAC.
// Accepts samples on a valid/ready port into a one-entry buffer and sends
// each one as a 16-bit SYNC-framed word {2'b00, pd_mode, sample}, MSB first.
// Optional build macro AUDIO_DAC_SIGNED_EN: input samples are two's
// complement and are converted to offset binary before buffering.
// Ports:
//   clk, reset            : system clock, synchronous active-high reset
//   sample, sample_valid  : sample input (offset binary by default)
//   sample_ready          : buffer empty, can accept
//   pd_mode               : power-down bits, captured when the shifter loads
//   sync_n, sclk, sdata   : DAC serial interface (all registered)
//   busy                  : FSM not in IDLE
//   frame_done            : one-cycle pulse on the first GAP cycle
//   state_dbg             : current FSM state, for observation
//
// Handshake: a sample transfers on a rising clk edge where sample_valid and
// sample_ready are both high; sample_ready depends only on the buffer state,
// never on sample_valid, and a deasserted sample_valid simply offers nothing.
module audio_dac_tx
  import audio_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int GAP_CYC = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                sample_valid,
  output logic                sample_ready,
  input  logic [1:0]          pd_mode,
  output logic                sync_n,
  output logic                sclk,
  output logic                sdata,
  output logic                busy,
  output logic                frame_done,
  output dac_state_t          state_dbg
);

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  dac_state_t            state_q, state_d;
  logic [SAMPLE_W-1:0]   hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic [DAC_WORD_W-1:0] shreg_q, shreg_d;
  logic [3:0]            bit_q, bit_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic                  sync_n_q, sync_n_d;
  logic                  sclk_q, sclk_d;
  logic                  sdata_q, sdata_d;
  logic                  done_q, done_d;
  logic                  busy_q;
  logic                  tick, tick_clr;
  logic [SAMPLE_W-1:0]   in_sample;

`ifdef AUDIO_DAC_SIGNED_EN
  // Flipping the sign bit maps two's complement onto offset binary.
  assign in_sample = {~sample[SAMPLE_W-1], sample[SAMPLE_W-2:0]};
`else
  assign in_sample = sample;
`endif

  sclk_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (state_q == ST_SHIFT),
    .clr   (tick_clr),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shreg_d     = shreg_q;
    bit_d       = bit_q;
    gap_d       = gap_q;
    sync_n_d    = sync_n_q;
    sclk_d      = sclk_q;
    sdata_d     = sdata_q;
    done_d      = 1'b0;
    tick_clr    = 1'b0;

    // Accept only into an empty buffer, so accept and load never coincide.
    if (sample_valid && !hold_full_q) begin
      hold_d      = in_sample;
      hold_full_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (hold_full_q) begin
          shreg_d     = {2'b00, pd_mode, hold_q};
          hold_full_d = 1'b0;
          sync_n_d    = 1'b0;
          sclk_d      = 1'b1;
          sdata_d     = 1'b0;  // word bit 15 is always zero
          bit_d       = 4'd0;
          tick_clr    = 1'b1;
          state_d     = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          if (sclk_q) begin
            // Falling edge: DAC samples sdata, which is held.
            sclk_d = 1'b0;
          end else if (bit_q == 4'd15) begin
            // Rising edge after the 16th falling edge closes the frame.
            sync_n_d = 1'b1;
            sclk_d   = 1'b1;
            sdata_d  = 1'b0;
            done_d   = 1'b1;
            gap_d    = '0;
            state_d  = ST_GAP;
          end else begin
            sclk_d  = 1'b1;
            sdata_d = shreg_q[DAC_WORD_W-2];
            shreg_d = {shreg_q[DAC_WORD_W-2:0], 1'b0};
            bit_d   = bit_q + 4'd1;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shreg_q     <= '0;
      bit_q       <= '0;
      gap_q       <= '0;
      sync_n_q    <= 1'b1;
      sclk_q      <= 1'b1;
      sdata_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shreg_q     <= shreg_d;
      bit_q       <= bit_d;
      gap_q       <= gap_d;
      sync_n_q    <= sync_n_d;
      sclk_q      <= sclk_d;
      sdata_q     <= sdata_d;
      done_q      <= done_d;
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  assign sample_ready = !hold_full_q;
  assign sync_n       = sync_n_q;
  assign sclk         = sclk_q;
  assign sdata        = sdata_q;
  assign busy         = busy_q;
  assign frame_done   = done_q;
  assign state_dbg    = state_q;

endmodule

// File: doc/audio_dac_tx.md
Name: audio_dac_tx

Overview:
- Serial transmitter for a Pmod DA2-class 12-bit DAC (DAC121S101 protocol); the output-side counterpart of the mic capture path.
- Accepts 12-bit samples, e.g. from the 20 kHz mic path, through a valid/ready handshake.
- Holds one sample in a single-entry buffer.
- Shifts each sample out as a 16-bit SYNC-framed word on sync_n/sclk/sdata, driven to a Pmod header by the top level.

Parameters:
- CLK_DIV, 4: clk cycles per SCLK half-period; SCLK = clk/(2*CLK_DIV), 12.5 MHz at 100 MHz. Legal range 1..255.
- GAP_CYC, 4: minimum clk cycles sync_n stays high between frames. Legal range ≥1.

Ports:
- clk  in  1  system clock (100 MHz)
- reset  in  1  synchronous, active-high reset
- sample  in  12  unsigned offset-binary sample, mid-scale 12'h800
- sample_valid  in  1  sample present
- sample_ready  out  1  buffer can accept a sample
- pd_mode  in  2  DAC power-down bits, sampled when the shifter loads; 2'b00 = normal
- sync_n  out  1  DAC frame sync, active low
- sclk  out  1  DAC serial clock, idle high
- sdata  out  1  DAC serial data, MSB first
- busy  out  1  high while the FSM is not in IDLE
- frame_done  out  1  one-cycle pulse when a frame completes

Behaviour:
- Reset values: sync_n=1, sclk=1, sdata=0, sample_ready=1, busy=0, frame_done=0. Buffer is emptied, FSM goes to IDLE, divider counter is cleared.
- Reset mid-frame aborts the frame the next cycle: sync_n goes high immediately, the partial word is discarded, and the buffered sample is discarded.
- All outputs are registered.

Holding buffer:
- sample_ready = !hold_full.
- A transfer occurs when sample_valid && sample_ready; the buffer latches sample.
- Simultaneous accept and drain cannot occur, because ready is low whenever the buffer is full.
- The buffer frees in the same cycle the shifter loads, so ready rises 1 cycle after the load. A new sample may be accepted while a frame is shifting.

Shift word: {2'b00, pd_mode, sample[11:0]}, 16 bits, MSB first.

FSM states: IDLE, SHIFT, GAP.
- IDLE: if hold_full, load the shifter and clear hold_full. Next cycle sync_n=0, sdata=bit15, sclk=1, and the FSM enters SHIFT with the divider counter at 0.
- Latency: sync_n falls exactly 2 clk cycles after the acceptance cycle when the FSM is idle.
- SHIFT: every CLK_DIV clk cycles sclk toggles.
  - On each 1->0 toggle (the DAC samples on the falling edge), sdata is unchanged.
  - On each 0->1 toggle, the shifter advances and sdata presents the next bit.
  - After the 16th falling edge, the next rising toggle ends the frame: sync_n=1, sclk=1, sdata=0, state GAP.
  - sync_n is low for exactly 32*CLK_DIV clk cycles per frame.
- GAP: hold for GAP_CYC cycles, then return to IDLE. frame_done pulses for 1 cycle on the first GAP cycle.
- Back-to-back frames: sync_n-high time is exactly GAP_CYC+1 cycles, counting the IDLE load cycle.
- busy = (state != IDLE).
- pd_mode changes during SHIFT have no effect on the frame in progress.
- sample_valid deasserting without a transfer has no effect; the handshake has no abort.

Optional Feature:
- Macro: AUDIO_DAC_SIGNED_EN.
- Defined: sample is treated as two's-complement. Bit 11 is inverted before buffering (offset-binary conversion), so 12'h000 is transmitted as 12'h800 and 12'h7FF as 12'hFFF.
- Undefined: sample is transmitted unmodified.
- Timing is identical either way.

Decomposition:
- Shared package audio_pkg:
  - SAMPLE_W=12 and DAC_WORD_W=16
  - PD_NORMAL=2'b00, PD_1K=2'b01, PD_100K=2'b10, PD_HIZ=2'b11
  - the FSM state typedef
- One natural sub-module: sclk_tick_gen, a CLK_DIV counter producing a half-period tick. It is enabled only in SHIFT and cleared on entry.

Test Plan:
- Reset: assert reset for 3 cycles mid-operation -> sync_n=1, sclk=1, sdata=0, sample_ready=1, busy=0 from the cycle after the reset edge.
- Single frame: CLK_DIV=4, GAP_CYC=4, pd_mode=0, send sample 12'hA5C -> sync_n falls 2 cycles after acceptance and stays low 128 cycles. 16 falling SCLK edges occur, and bits sampled on falling edges equal 16'h0A5C. frame_done pulses once.
- Buffering and back-to-back: hold sample_valid high with 12'h001 then 12'hFFF -> the second sample is accepted 1 cycle after the first frame's shifter load. Frames are 16'h0001 and 16'h0FFF, with exactly 5 cycles of sync_n high between them. sample_ready stays low while the buffer is full.
- Power-down bits: pd_mode=2'b11, sample 12'h000 -> word 16'h3000. Changing pd_mode to 0 during the frame does not alter it.
- Abort: reset at the 7th SCLK falling edge with the buffer full -> sync_n high next cycle. No frame_done pulse. No further frame without a new accepted sample.
- AUDIO_DAC_SIGNED_EN defined, sample 12'h000 -> shifted word 16'h0800. Sample 12'h800 -> word 16'h0000.
